// File: rtl/scalar_wb_ctrl.sv
// Scalar writeback controller: merges ALU results and buffered load returns
// into one registered register-file write port, and tracks pending loads.
module scalar_wb_ctrl #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_vld,
    input  logic [ADDR_W-1:0]        alu_dst,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     ld_issue,
    input  logic [ADDR_W-1:0]        ld_issue_dst,
    input  logic                     ld_vld,
    output logic                     ld_rdy,
    input  logic [ADDR_W-1:0]        ld_dst,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_dst,
    output logic [DATA_W-1:0]        wr_data,
    output logic [(1<<ADDR_W)-1:0]   pend,
    output logic                     busy
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } ld_entry_t;

    ld_entry_t              fifo_mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;

    logic                   full_c;
    logic                   empty_c;
    logic                   push_c;
    logic                   pop_c;
    ld_entry_t              head_c;
    logic [NREG-1:0]        pend_nxt_c;
    logic [CNT_W-1:0]       count_nxt_c;

    // Full is derived from the registered count only, so a same-cycle pop
    // never re-opens ld_rdy.
    always_comb begin
        full_c  = (count == CNT_W'(DEPTH));
        empty_c = (count == '0);
        ld_rdy  = !full_c && !rst;
        push_c  = ld_vld && ld_rdy;
        pop_c   = !alu_vld && !empty_c && !rst;
        head_c  = fifo_mem[rd_ptr];
        busy    = !rst && (!empty_c || (|pend));
    end

    // Occupancy and scoreboard next state; a set on the same bit beats a clear.
    always_comb begin
        count_nxt_c = count;
        case ({push_c, pop_c})
            2'b10:   count_nxt_c = count + CNT_W'(1);
            2'b01:   count_nxt_c = count - CNT_W'(1);
            default: count_nxt_c = count;
        endcase

        pend_nxt_c = pend;
        if (pop_c) begin
            pend_nxt_c[head_c.dst] = 1'b0;
        end
        if (ld_issue) begin
            pend_nxt_c[ld_issue_dst] = 1'b1;
        end
    end

    // Entry storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= '{dst: ld_dst, data: ld_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pend   <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count_nxt_c;
            pend  <= pend_nxt_c;
        end
    end

    // Write port: ALU first, then FIFO head; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_dst  <= '0;
            wr_data <= '0;
        end else if (alu_vld) begin
            wr_en   <= 1'b1;
            wr_dst  <= alu_dst;
            wr_data <= alu_data;
        end else if (pop_c) begin
            wr_en   <= 1'b1;
            wr_dst  <= head_c.dst;
            wr_data <= head_c.data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scalar_wb_ctrl.sv
// Directed bench for scalar_wb_ctrl: vector table plus hand-written
// backpressure and mid-operation reset sequences.
module tb_scalar_wb_ctrl;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREG   = 1 << ADDR_W;
    localparam int unsigned NVEC   = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_vld;
    logic [ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0] alu_data;
    logic              ld_issue;
    logic [ADDR_W-1:0] ld_issue_dst;
    logic              ld_vld;
    logic              ld_rdy;
    logic [ADDR_W-1:0] ld_dst;
    logic [DATA_W-1:0] ld_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_dst;
    logic [DATA_W-1:0] wr_data;
    logic [NREG-1:0]   pend;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    scalar_wb_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .alu_vld(alu_vld), .alu_dst(alu_dst), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_dst(ld_issue_dst),
        .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_dst(ld_dst), .ld_data(ld_data),
        .wr_en(wr_en), .wr_dst(wr_dst), .wr_data(wr_data),
        .pend(pend), .busy(busy)
    );

    typedef struct {
        logic              alu_vld;
        logic [ADDR_W-1:0] alu_dst;
        logic [DATA_W-1:0] alu_data;
        logic              ld_issue;
        logic [ADDR_W-1:0] ld_issue_dst;
        logic              ld_vld;
        logic [ADDR_W-1:0] ld_dst;
        logic [DATA_W-1:0] ld_data;
        logic              e_wr_en;
        logic [ADDR_W-1:0] e_wr_dst;
        logic [DATA_W-1:0] e_wr_data;
        logic [NREG-1:0]   e_pend;
        logic              e_rdy;
        logic              e_busy;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic a, input int ad, input int adat,
        input logic li, input int lid,
        input logic lv, input int ld, input int ldat,
        input logic ew, input int ewd, input int ewdat,
        input int ep, input logic er, input logic eb);
        vec_t v;
        v.alu_vld = a;   v.alu_dst = ADDR_W'(ad);  v.alu_data = DATA_W'(adat);
        v.ld_issue = li; v.ld_issue_dst = ADDR_W'(lid);
        v.ld_vld = lv;   v.ld_dst = ADDR_W'(ld);   v.ld_data = DATA_W'(ldat);
        v.e_wr_en = ew;  v.e_wr_dst = ADDR_W'(ewd); v.e_wr_data = DATA_W'(ewdat);
        v.e_pend = NREG'(ep); v.e_rdy = er; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        alu_vld = 1'b0; alu_dst = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_dst = '0;
        ld_vld = 1'b0; ld_dst = '0; ld_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Columns: alu(v,dst,data) issue(v,dst) ret(v,dst,data) | wr(en,dst,data) pend rdy busy
        vecs[0]  = mk(0,0,0,      0,0, 0,0,0,       0,0,0,       'h00,1,0);
        vecs[1]  = mk(1,5,'h1234, 0,0, 0,0,0,       1,5,'h1234,  'h00,1,0);
        vecs[2]  = mk(0,0,0,      0,0, 0,0,0,       0,5,'h1234,  'h00,1,0);
        vecs[3]  = mk(0,0,0,      1,3, 0,0,0,       0,5,'h1234,  'h08,1,1);
        vecs[4]  = mk(0,0,0,      0,0, 1,3,'hBEEF,  0,5,'h1234,  'h08,1,1);
        vecs[5]  = mk(0,0,0,      0,0, 0,0,0,       1,3,'hBEEF,  'h00,1,0);
        vecs[6]  = mk(0,0,0,      0,0, 0,0,0,       0,3,'hBEEF,  'h00,1,0);
        vecs[7]  = mk(0,0,0,      1,1, 0,0,0,       0,3,'hBEEF,  'h02,1,1);
        vecs[8]  = mk(0,0,0,      1,2, 0,0,0,       0,3,'hBEEF,  'h06,1,1);
        vecs[9]  = mk(1,4,'hAAAA, 0,0, 1,1,'h0001,  1,4,'hAAAA,  'h06,1,1);
        vecs[10] = mk(1,4,'hBBBB, 0,0, 1,2,'h0002,  1,4,'hBBBB,  'h06,1,1);
        vecs[11] = mk(1,4,'hCCCC, 0,0, 0,0,0,       1,4,'hCCCC,  'h06,1,1);
        vecs[12] = mk(0,0,0,      0,0, 0,0,0,       1,1,'h0001,  'h04,1,1);
        vecs[13] = mk(0,0,0,      0,0, 0,0,0,       1,2,'h0002,  'h00,1,0);
        vecs[14] = mk(0,0,0,      0,0, 0,0,0,       0,2,'h0002,  'h00,1,0);
        vecs[15] = mk(0,0,0,      1,6, 0,0,0,       0,2,'h0002,  'h40,1,1);
        vecs[16] = mk(0,0,0,      0,0, 1,6,'h6666,  0,2,'h0002,  'h40,1,1);
        vecs[17] = mk(0,0,0,      1,6, 0,0,0,       1,6,'h6666,  'h40,1,1);
        vecs[18] = mk(0,0,0,      0,0, 1,6,'h7777,  0,6,'h6666,  'h40,1,1);
        vecs[19] = mk(0,0,0,      0,0, 0,0,0,       1,6,'h7777,  'h00,1,0);

        idle();
        rst = 1'b1;
        tick();
        chk("rdy_in_reset", 32'(ld_rdy), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rdy_after_reset", 32'(ld_rdy), 32'd1);
        chk("wr_en_after_reset", 32'(wr_en), 32'd0);
        chk("pend_after_reset", 32'(pend), 32'd0);

        for (int i = 0; i < int'(NVEC); i++) begin
            alu_vld = vecs[i].alu_vld; alu_dst = vecs[i].alu_dst; alu_data = vecs[i].alu_data;
            ld_issue = vecs[i].ld_issue; ld_issue_dst = vecs[i].ld_issue_dst;
            ld_vld = vecs[i].ld_vld; ld_dst = vecs[i].ld_dst; ld_data = vecs[i].ld_data;
            tick();
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].e_wr_en));
            chk($sformatf("v%0d_wr_dst", i), 32'(wr_dst), 32'(vecs[i].e_wr_dst));
            chk($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].e_wr_data));
            chk($sformatf("v%0d_pend", i), 32'(pend), 32'(vecs[i].e_pend));
            chk($sformatf("v%0d_ld_rdy", i), 32'(ld_rdy), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
        end
        idle();

        // Backpressure: ALU held while five returns arrive back to back.
        begin
            int in_idx = 0;
            int out_idx = 0;
            int cyc = 0;
            for (int c = 0; c < 6; c++) begin
                alu_vld = 1'b1; alu_dst = 3'd7; alu_data = DATA_W'(16'h5A00 + c);
                ld_vld = (in_idx < 5);
                ld_dst = ADDR_W'(in_idx + 1); ld_data = DATA_W'(16'hD001 + in_idx);
                #1;
                chk($sformatf("bp_rdy_c%0d", c), 32'(ld_rdy), (c < 4) ? 32'd1 : 32'd0);
                if (ld_vld && ld_rdy) in_idx++;
                tick();
                chk($sformatf("bp_alu_en_c%0d", c), 32'(wr_en), 32'd1);
                chk($sformatf("bp_alu_data_c%0d", c), 32'(wr_data), 32'h5A00 + 32'(c));
            end
            alu_vld = 1'b0;
            while (out_idx < 5 && cyc < 12) begin
                ld_vld = (in_idx < 5);
                ld_dst = ADDR_W'(in_idx + 1); ld_data = DATA_W'(16'hD001 + in_idx);
                #1;
                if (cyc == 0) chk("bp_rdy_full_pop", 32'(ld_rdy), 32'd0);
                if (ld_vld && ld_rdy) in_idx++;
                tick();
                if (wr_en) begin
                    chk($sformatf("bp_ld_dst_%0d", out_idx), 32'(wr_dst), 32'(out_idx + 1));
                    chk($sformatf("bp_ld_data_%0d", out_idx), 32'(wr_data), 32'hD001 + 32'(out_idx));
                    out_idx++;
                end
                cyc++;
            end
            chk("bp_writes_drained", 32'(out_idx), 32'd5);
            idle();
            tick();
            chk("bp_idle_after", 32'(wr_en), 32'd0);
            chk("bp_busy_after", 32'(busy), 32'd0);
        end

        // Reset mid-operation with three queued returns and pend = 8'h0A.
        alu_vld = 1'b1; alu_dst = 3'd0; alu_data = 16'h0000;
        ld_issue = 1'b1; ld_issue_dst = 3'd1; ld_vld = 1'b1; ld_dst = 3'd1; ld_data = 16'h1111;
        tick();
        ld_issue_dst = 3'd3; ld_dst = 3'd3; ld_data = 16'h3333;
        tick();
        ld_issue = 1'b0; ld_data = 16'h3334;
        tick();
        chk("rst_pre_pend", 32'(pend), 32'h0A);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        idle();
        rst = 1'b1;
        #1;
        chk("rst_mid_rdy", 32'(ld_rdy), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_post_wr_en", 32'(wr_en), 32'd0);
        chk("rst_post_wr_dst", 32'(wr_dst), 32'd0);
        chk("rst_post_wr_data", 32'(wr_data), 32'd0);
        chk("rst_post_pend", 32'(pend), 32'd0);
        chk("rst_post_busy", 32'(busy), 32'd0);
        chk("rst_post_rdy", 32'(ld_rdy), 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rst_no_stale_%0d", c), 32'(wr_en), 32'd0);
            chk($sformatf("rst_busy_%0d", c), 32'(busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
